// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response channel,
// redirect input, and the decoupled instruction output handshake.
//   master : the fetch unit side (drives requests and the instruction stream)
//   slave  : the environment side (memory, branch unit, consumer)
interface fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_o;
  logic [DATA_WIDTH-1:0] imem_addr_o;
  logic                  imem_rvalid_i;
  logic [DATA_WIDTH-1:0] imem_rdata_i;
  logic                  redirect_i;
  logic [DATA_WIDTH-1:0] redirect_pc_i;
  logic                  instr_valid_o;
  logic                  instr_ready_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [DATA_WIDTH-1:0] pc_o;
  logic [DATA_WIDTH-1:0] pc_plus_4_o;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus_4_o,
    input  imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus_4_o,
    output imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches once triggered,
// buffers in-order responses with their PCs in a small FIFO, and supports
// flush/refetch on redirect with discard of stale in-flight responses.
// Ports:
//   clk     - single clock, rising edge
//   rst     - asynchronous active-low reset
//   trigger - start request, leaves IDLE on first high cycle
//   bus     - fetch_unit_if.master (imem request/response, redirect, instr out)
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'hBFC00000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trigger,
  fetch_unit_if.master  bus
);
  localparam int                    PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                    CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] STEP    = DATA_WIDTH'(4);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic [CNT_W-1:0]      out_q, out_d;
  logic [CNT_W-1:0]      drop_q, drop_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W:0]        inflight;
  logic [DATA_WIDTH-1:0] target;
  logic                  req, rsp_ok, push, pop, flush, head_valid;

  logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem    [FIFO_DEPTH];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_d     = drop_q;
    req        = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    target     = bus.redirect_pc_i & ~DATA_WIDTH'(3);
    inflight   = {1'b0, occ_q} + {1'b0, out_q};
    // A response with nothing outstanding is a protocol error and is dropped.
    rsp_ok     = bus.imem_rvalid_i && (out_q != '0);

    case (state_q)
      IDLE: begin
        if (trigger) state_d = RUN;
      end
      RUN: begin
        flush = bus.redirect_i;
        // Only request when a FIFO slot is reserved for the eventual response.
        req   = !flush && (inflight < {1'b0, DEPTH_C});
        pop   = (occ_q != '0) && bus.instr_ready_i;
        push  = rsp_ok && (drop_q == '0) && !flush;
      end
      default: state_d = IDLE;
    endcase

    out_d = out_q + CNT_W'(req) - CNT_W'(rsp_ok);
    occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
    if (rsp_ok && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    if (req)  fetch_pc_d = fetch_pc_q + STEP;
    if (push) begin
      wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      resp_pc_d = resp_pc_q + STEP;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    // Everything still in flight after this edge is stale, including requests
    // already marked for dropping; a response landing now is discarded too.
    if (flush) begin
      occ_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drop_d     = out_d;
      fetch_pc_d = target;
      resp_pc_d  = target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      occ_q      <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      occ_q      <= occ_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= bus.imem_rdata_i;
      pc_mem[wr_ptr_q]    <= resp_pc_q;
    end
  end

  // Storage is not reset, so an empty FIFO presents fixed values instead.
  assign head_valid        = (occ_q != '0);
  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = head_valid;
  assign bus.instr_o       = head_valid ? instr_mem[rd_ptr_q] : '0;
  assign bus.pc_o          = head_valid ? pc_mem[rd_ptr_q] : RESET_PC;
  assign bus.pc_plus_4_o   = bus.pc_o + STEP;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory responder with
// configurable latency, and a sequential-PC reference model of the
// delivered instruction stream.
module tb_fetch_unit;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'hBFC00000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trigger = 1'b0;

  fetch_unit_if #(.DATA_WIDTH(DW)) bus();

  fetch_unit #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .bus(bus)
  );

  always #5 clk = ~clk;

  int          compared = 0;
  int          mismatched = 0;
  int unsigned lat_min = 1, lat_max = 1;
  logic [31:0] key = '0;
  longint      cyc = 0;
  int unsigned req_count = 0;

  typedef struct { longint due; logic [31:0] data; } resp_t;
  resp_t pend[$];

  // Memory: returns addr^key, in order, at least one cycle after the request.
  initial begin
    longint due, last_due;
    last_due = 0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        pend.delete();
        last_due = 0;
        bus.imem_rvalid_i = 1'b0;
      end else begin
        if (pend.size() != 0 && pend[0].due <= cyc) begin
          bus.imem_rvalid_i = 1'b1;
          bus.imem_rdata_i  = pend[0].data;
          void'(pend.pop_front());
        end else begin
          bus.imem_rvalid_i = 1'b0;
          bus.imem_rdata_i  = $urandom;
        end
        if (bus.imem_req_o === 1'b1) begin
          due = cyc + longint'($urandom_range(lat_max, lat_min));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend.push_back('{due, bus.imem_addr_o ^ key});
          req_count++;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0; trigger = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; req_count = 0;
    @(posedge clk); #1 trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    compared++; if (bus.imem_req_o !== 1'b0) begin mismatched++; $display("FAIL rst_req: got %b want 0", bus.imem_req_o); end
    compared++; if (bus.instr_valid_o !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid_o); end
    compared++; if (bus.imem_addr_o !== RPC) begin mismatched++; $display("FAIL rst_addr: got %h want %h", bus.imem_addr_o, RPC); end
    compared++; if (bus.instr_o !== 32'h0) begin mismatched++; $display("FAIL rst_instr: got %h want 0", bus.instr_o); end
    compared++; if (bus.pc_o !== RPC) begin mismatched++; $display("FAIL rst_pc: got %h want %h", bus.pc_o, RPC); end
    compared++; if (bus.pc_plus_4_o !== RPC + 32'd4) begin mismatched++; $display("FAIL rst_pc4: got %h want %h", bus.pc_plus_4_o, RPC + 32'd4); end
    @(posedge clk); #1 rst = 1'b1;
    // Idle with trigger low; redirect must be ignored here.
    for (int i = 0; i < 10; i++) begin
      bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_1234;
      @(negedge clk);
      compared++; if (bus.imem_req_o !== 1'b0) begin mismatched++; $display("FAIL idle_req: got %b want 0", bus.imem_req_o); end
      compared++; if (bus.instr_valid_o !== 1'b0) begin mismatched++; $display("FAIL idle_valid: got %b want 0", bus.instr_valid_o); end
      @(posedge clk); #1;
    end
    bus.redirect_i = 1'b0; trigger = 1'b1;
    @(negedge clk);
    compared++; if (bus.imem_req_o !== 1'b0) begin mismatched++; $display("FAIL trig_cycle_req: got %b want 0", bus.imem_req_o); end
    @(posedge clk); #1 trigger = 1'b0;
    @(negedge clk);
    compared++; if (bus.imem_req_o !== 1'b1) begin mismatched++; $display("FAIL first_req: got %b want 1", bus.imem_req_o); end
    compared++; if (bus.imem_addr_o !== RPC) begin mismatched++; $display("FAIL first_addr: got %h want %h", bus.imem_addr_o, RPC); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    int pops;
    lat_min = 1; lat_max = 1; key = '0; bus.instr_ready_i = 1'b1;
    do_reset();
    exp = RPC; pops = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.instr_valid_o) begin
        compared++; if (bus.pc_o !== exp) begin mismatched++; $display("FAIL stream_pc: got %h want %h", bus.pc_o, exp); end
        compared++; if (bus.instr_o !== exp) begin mismatched++; $display("FAIL stream_instr: got %h want %h", bus.instr_o, exp); end
        compared++; if (bus.pc_plus_4_o !== exp + 32'd4) begin mismatched++; $display("FAIL stream_pc4: got %h want %h", bus.pc_plus_4_o, exp + 32'd4); end
        exp += 32'd4; pops++;
      end
      @(posedge clk); #1;
    end
    // Two cycles of fill, then one instruction every cycle.
    compared++; if (pops != 38) begin mismatched++; $display("FAIL stream_rate: got %0d pops want 38", pops); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    int pops;
    lat_min = 1; lat_max = 1; key = '0; bus.instr_ready_i = 1'b0;
    do_reset();
    repeat (12) begin @(posedge clk); #1; end
    @(negedge clk);
    compared++; if (req_count != DEPTH) begin mismatched++; $display("FAIL bp_req_count: got %0d want %0d", req_count, DEPTH); end
    compared++; if (bus.imem_req_o !== 1'b0) begin mismatched++; $display("FAIL bp_req_stall: got %b want 0", bus.imem_req_o); end
    compared++; if (bus.instr_valid_o !== 1'b1) begin mismatched++; $display("FAIL bp_valid: got %b want 1", bus.instr_valid_o); end
    compared++; if (bus.pc_o !== RPC) begin mismatched++; $display("FAIL bp_head_pc: got %h want %h", bus.pc_o, RPC); end
    @(posedge clk); #1 bus.instr_ready_i = 1'b1;
    exp = RPC; pops = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.instr_valid_o) begin
        compared++; if (bus.pc_o !== exp) begin mismatched++; $display("FAIL bp_pc: got %h want %h", bus.pc_o, exp); end
        compared++; if (bus.instr_o !== exp) begin mismatched++; $display("FAIL bp_instr: got %h want %h", bus.instr_o, exp); end
        exp += 32'd4; pops++;
      end
      @(posedge clk); #1;
    end
    compared++; if (pops != 12) begin mismatched++; $display("FAIL bp_resume_rate: got %0d pops want 12", pops); end
  endtask

  task automatic test_redirect();
    logic [31:0] exp;
    int pops;
    lat_min = 3; lat_max = 3; key = $urandom; bus.instr_ready_i = 1'b1;
    do_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Two requests are in flight at this point.
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_0103;
    @(negedge clk);
    compared++; if (bus.imem_req_o !== 1'b0) begin mismatched++; $display("FAIL redir_no_req: got %b want 0", bus.imem_req_o); end
    @(posedge clk); #1 bus.redirect_i = 1'b0;
    exp = 32'h0000_0100; pops = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.instr_valid_o) begin
        compared++; if (bus.pc_o !== exp) begin mismatched++; $display("FAIL redir_pc: got %h want %h", bus.pc_o, exp); end
        compared++; if (bus.instr_o !== (exp ^ key)) begin mismatched++; $display("FAIL redir_instr: got %h want %h", bus.instr_o, exp ^ key); end
        exp += 32'd4; pops++;
      end
      @(posedge clk); #1;
    end
    compared++; if (pops < 4) begin mismatched++; $display("FAIL redir_progress: got %0d pops want >=4", pops); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    int pops;
    logic saw_zero_req;
    lat_min = 1; lat_max = 1; key = '0; bus.instr_ready_i = 1'b1;
    do_reset();
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFF9;
    @(negedge clk);
    @(posedge clk); #1 bus.redirect_i = 1'b0;
    exp = 32'hFFFF_FFF8; pops = 0; saw_zero_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.imem_req_o && bus.imem_addr_o == 32'h0) saw_zero_req = 1'b1;
      if (bus.instr_valid_o) begin
        compared++; if (bus.pc_o !== exp) begin mismatched++; $display("FAIL wrap_pc: got %h want %h", bus.pc_o, exp); end
        compared++; if (bus.pc_plus_4_o !== exp + 32'd4) begin mismatched++; $display("FAIL wrap_pc4: got %h want %h", bus.pc_plus_4_o, exp + 32'd4); end
        exp += 32'd4; pops++;
      end
      @(posedge clk); #1;
    end
    compared++; if (saw_zero_req !== 1'b1) begin mismatched++; $display("FAIL wrap_addr0: got %b want 1", saw_zero_req); end
    compared++; if (pops < 4) begin mismatched++; $display("FAIL wrap_progress: got %0d pops want >=4", pops); end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    int pops;
    lat_min = 1; lat_max = 4; key = $urandom; bus.instr_ready_i = 1'b1;
    do_reset();
    exp = RPC; pops = 0;
    for (int i = 0; i < 800; i++) begin
      bus.instr_ready_i = ($urandom_range(3, 0) != 0);
      bus.redirect_i    = ($urandom_range(15, 0) == 0);
      bus.redirect_pc_i = $urandom;
      @(negedge clk);
      if (bus.imem_req_o) begin
        compared++; if (bus.imem_addr_o[1:0] !== 2'b00) begin mismatched++; $display("FAIL rnd_addr_align: got %h", bus.imem_addr_o); end
      end
      if (bus.instr_valid_o && bus.instr_ready_i) begin
        compared++; if (bus.pc_o !== exp) begin mismatched++; $display("FAIL rnd_pc: got %h want %h", bus.pc_o, exp); end
        compared++; if (bus.instr_o !== (exp ^ key)) begin mismatched++; $display("FAIL rnd_instr: got %h want %h", bus.instr_o, exp ^ key); end
        compared++; if (bus.pc_plus_4_o !== exp + 32'd4) begin mismatched++; $display("FAIL rnd_pc4: got %h want %h", bus.pc_plus_4_o, exp + 32'd4); end
        exp += 32'd4; pops++;
      end
      if (bus.redirect_i) exp = bus.redirect_pc_i & ~32'h3;
      @(posedge clk); #1;
    end
    bus.redirect_i = 1'b0;
    compared++; if (pops < 100) begin mismatched++; $display("FAIL rnd_progress: got %0d pops want >=100", pops); end
  endtask

  task automatic test_async_reset();
    logic [31:0] exp;
    int pops;
    lat_min = 1; lat_max = 1; key = '0; bus.instr_ready_i = 1'b0;
    do_reset();
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    compared++; if (bus.instr_valid_o !== 1'b1) begin mismatched++; $display("FAIL ar_full_valid: got %b want 1", bus.instr_valid_o); end
    @(posedge clk); #3 rst = 1'b0;
    #1;
    compared++; if (bus.imem_req_o !== 1'b0) begin mismatched++; $display("FAIL ar_req: got %b want 0", bus.imem_req_o); end
    compared++; if (bus.instr_valid_o !== 1'b0) begin mismatched++; $display("FAIL ar_valid: got %b want 0", bus.instr_valid_o); end
    compared++; if (bus.imem_addr_o !== RPC) begin mismatched++; $display("FAIL ar_addr: got %h want %h", bus.imem_addr_o, RPC); end
    compared++; if (bus.instr_o !== 32'h0) begin mismatched++; $display("FAIL ar_instr: got %h want 0", bus.instr_o); end
    compared++; if (bus.pc_o !== RPC) begin mismatched++; $display("FAIL ar_pc: got %h want %h", bus.pc_o, RPC); end
    compared++; if (bus.pc_plus_4_o !== RPC + 32'd4) begin mismatched++; $display("FAIL ar_pc4: got %h want %h", bus.pc_plus_4_o, RPC + 32'd4); end
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1; trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0; bus.instr_ready_i = 1'b1;
    @(negedge clk);
    compared++; if (bus.imem_req_o !== 1'b1) begin mismatched++; $display("FAIL ar_restart_req: got %b want 1", bus.imem_req_o); end
    compared++; if (bus.imem_addr_o !== RPC) begin mismatched++; $display("FAIL ar_restart_addr: got %h want %h", bus.imem_addr_o, RPC); end
    @(posedge clk); #1;
    exp = RPC; pops = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.instr_valid_o) begin
        compared++; if (bus.pc_o !== exp) begin mismatched++; $display("FAIL ar_pc_seq: got %h want %h", bus.pc_o, exp); end
        exp += 32'd4; pops++;
      end
      @(posedge clk); #1;
    end
    compared++; if (pops < 4) begin mismatched++; $display("FAIL ar_progress: got %0d pops want >=4", pops); end
  endtask

  initial begin
    bus.instr_ready_i = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
